// File: rtl/clock_time_setter_if.sv
// clock_time_setter_if: mode/increment inputs and time/display outputs of the clock core
interface clock_time_setter_if;
  logic [1:0] mode;
  logic       inc_pulse;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       blink;
  modport master (output mode, inc_pulse, input hours, minutes, seconds, sec_tick, blink);
  modport slave (input mode, inc_pulse, output hours, minutes, seconds, sec_tick, blink);
endinterface

// File: rtl/clock_time_setter.sv
// clock_time_setter: 24-hour HH:MM:SS clock with hour/minute set modes and set-field blink
module clock_time_setter #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 50000000
) (
  input logic clk,
  input logic rst,
  clock_time_setter_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [PW-1:0] pre_cnt;
  logic [BW-1:0] blk_cnt;
  logic [1:0]    prev_mode;
  logic          set_mode, swap, tick_now;
  always_comb begin
    set_mode = bus.mode == 2'd1 || bus.mode == 2'd2;
    swap     = set_mode && (prev_mode == 2'd1 || prev_mode == 2'd2) && prev_mode != bus.mode;
    tick_now = bus.mode == 2'd0 && pre_cnt == PW'(TICK_DIV - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      blk_cnt     <= '0;
      prev_mode   <= 2'd0;
      bus.hours   <= '0;
      bus.minutes <= '0;
      bus.seconds <= '0;
      bus.sec_tick <= 1'b0;
      bus.blink   <= 1'b0;
    end else begin
      prev_mode    <= bus.mode;
      pre_cnt      <= (bus.mode != 2'd0 || tick_now) ? '0 : pre_cnt + 1'b1;
      bus.sec_tick <= tick_now;
      if (tick_now) begin
        bus.seconds <= bus.seconds == 6'd59 ? 6'd0 : bus.seconds + 6'd1;
        if (bus.seconds == 6'd59) begin
          bus.minutes <= bus.minutes == 6'd59 ? 6'd0 : bus.minutes + 6'd1;
          if (bus.minutes == 6'd59)
            bus.hours <= bus.hours == 5'd23 ? 5'd0 : bus.hours + 5'd1;
        end
      end else if (bus.mode == 2'd1 && bus.inc_pulse) begin
        bus.hours <= bus.hours == 5'd23 ? 5'd0 : bus.hours + 5'd1;
      end else if (bus.mode == 2'd2 && bus.inc_pulse) begin
        bus.minutes <= bus.minutes == 6'd59 ? 6'd0 : bus.minutes + 6'd1;
        bus.seconds <= 6'd0;
      end
      // adjusting or switching fields restarts the blink phase with the field visible
      if (!set_mode || bus.inc_pulse || swap) begin
        blk_cnt   <= '0;
        bus.blink <= 1'b0;
      end else if (blk_cnt == BW'(BLINK_DIV - 1)) begin
        blk_cnt   <= '0;
        bus.blink <= ~bus.blink;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end
endmodule
